// File: rtl/gaussian_pkg.sv
// Shared constants for the streaming 3x3 Gaussian blur: kernel weights,
// normalisation, border-mode encoding and controller state encoding.
package gaussian_pkg;
   localparam logic [2:0] K_CORNER = 3'd1;
   localparam logic [2:0] K_EDGE   = 3'd2;
   localparam logic [2:0] K_CENTER = 3'd4;

   localparam int NORM_SHIFT = 4;
   localparam int ROUND_C    = 8;

   localparam logic BORDER_ZERO = 1'b0;
   localparam logic BORDER_REPL = 1'b1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;

   function automatic logic [2:0] kernel_weight(input int r, input int c);
      if (r == 1 && c == 1) return K_CENTER;
      if (r == 1 || c == 1) return K_EDGE;
      return K_CORNER;
   endfunction
endpackage

// File: rtl/gaussian_line_buffer.sv
// One-line circular delay: each advance returns the pixel written IMG_W
// advances earlier and stores the new one in its slot.
module gaussian_line_buffer #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   localparam int PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic [IMG_W-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]             ptr_q, ptr_d;

   assign dout = mem_q[ptr_q];

   always_comb begin
      mem_d = mem_q;
      ptr_d = ptr_q;
      if (adv) begin
         mem_d[ptr_q] = din;
         ptr_d = (ptr_q == PTR_W'(IMG_W - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/gaussian_blur_stream.sv
// Streaming 3x3 Gaussian blur with two line buffers, valid/ready on both
// sides, zero/replicate borders, rounding and an end-of-frame flush.
module gaussian_blur_stream
   import gaussian_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              border_mode,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_eol,
   output logic              m_eof
);
   localparam int SUM_W = DATA_W + 4;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic [1:0]       state_q, state_d;
   logic             en_q, en_d, mode_q, mode_d, wv_q, wv_d, done_q, done_d;
   logic [COL_W-1:0] in_col_q, in_col_d, out_col_q, out_col_d, win_col_q, win_col_d;
   logic [ROW_W-1:0] in_row_q, in_row_d, out_row_q, out_row_d, win_row_q, win_row_d;
   logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
   logic             m_valid_q, m_valid_d, m_eol_q, m_eol_d, m_eof_q, m_eof_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [DATA_W-1:0] lb0_out, lb1_out, push_px;
   logic             out_free, accept, flush_adv, adv, produce, win_move;
   logic [SUM_W-1:0] sum, rounded;

   assign out_free  = !m_valid_q || m_ready;
   assign s_ready   = en_q && (state_q != FLUSH) && out_free;
   assign accept    = s_valid && s_ready;
   assign flush_adv = (state_q == FLUSH) && out_free && !done_q;
   assign adv       = accept || flush_adv;
   assign produce   = (accept && state_q == RUN) || flush_adv;
   assign win_move  = wv_q && out_free;
   assign push_px   = accept ? s_data : '0;

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_eol   = m_eol_q;
   assign m_eof   = m_eof_q;

   gaussian_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb0 (
      .clk(clk), .rst_n(rst_n), .adv(adv), .din(push_px), .dout(lb0_out));
   gaussian_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb1 (
      .clk(clk), .rst_n(rst_n), .adv(adv), .din(lb0_out), .dout(lb1_out));

   // Out-of-frame taps clamp to the centre row/column; zero mode then blanks them.
   always_comb begin
      logic              row_out, col_out;
      logic [DATA_W-1:0] t;
      sum = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            row_out = (r == 0 && win_row_q == '0) || (r == 2 && win_row_q == LAST_ROW);
            col_out = (c == 0 && win_col_q == '0) || (c == 2 && win_col_q == LAST_COL);
            t = win_q[row_out ? 1 : r][col_out ? 1 : c];
            if (mode_q == BORDER_ZERO && (row_out || col_out)) t = '0;
            sum = sum + SUM_W'(t) * SUM_W'(kernel_weight(r, c));
         end
      end
      rounded = sum + SUM_W'(ROUND_C);
   end

   always_comb begin
      state_d   = state_q;   en_d      = 1'b1;      mode_d    = mode_q;
      wv_d      = wv_q;      done_d    = done_q;    win_d     = win_q;
      in_col_d  = in_col_q;  in_row_d  = in_row_q;
      out_col_d = out_col_q; out_row_d = out_row_q;
      win_col_d = win_col_q; win_row_d = win_row_q;
      m_valid_d = m_valid_q; m_data_d  = m_data_q;
      m_eol_d   = m_eol_q;   m_eof_d   = m_eof_q;

      // Window column shift: newest column enters at index 2, centre at 1.
      if (adv) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_out;
         win_d[1][2] = lb0_out;
         win_d[2][2] = push_px;
      end

      if (produce) begin
         wv_d      = 1'b1;
         win_col_d = out_col_q;
         win_row_d = out_row_q;
         if (out_col_q == LAST_COL) begin
            out_col_d = '0;
            if (out_row_q == LAST_ROW) begin
               out_row_d = '0;
               done_d    = 1'b1;
            end else begin
               out_row_d = out_row_q + ROW_W'(1);
            end
         end else begin
            out_col_d = out_col_q + COL_W'(1);
         end
      end else if (win_move) begin
         wv_d = 1'b0;
      end

      if (win_move) begin
         m_valid_d = 1'b1;
         m_data_d  = DATA_W'(rounded >> NORM_SHIFT);
         m_eol_d   = (win_col_q == LAST_COL);
         m_eof_d   = (win_col_q == LAST_COL) && (win_row_q == LAST_ROW);
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end

      if (accept) begin
         if (in_col_q == LAST_COL) begin
            in_col_d = '0;
            in_row_d = (in_row_q == LAST_ROW) ? '0 : in_row_q + ROW_W'(1);
         end else begin
            in_col_d = in_col_q + COL_W'(1);
         end
      end

      case (state_q)
         IDLE:  if (accept) begin
                   state_d = FILL;
                   mode_d  = border_mode;
                end
         FILL:  if (accept && in_row_q == ROW_W'(1) && in_col_q == '0) state_d = RUN;
         RUN:   if (accept && in_row_q == LAST_ROW && in_col_q == LAST_COL) state_d = FLUSH;
         default: if (m_valid_q && m_ready && m_eof_q) begin
                   state_d = IDLE;
                   done_d  = 1'b0;
                end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;  en_q      <= 1'b0;  mode_q    <= BORDER_ZERO;
         wv_q      <= 1'b0;  done_q    <= 1'b0;  win_q     <= '0;
         in_col_q  <= '0;    in_row_q  <= '0;
         out_col_q <= '0;    out_row_q <= '0;
         win_col_q <= '0;    win_row_q <= '0;
         m_valid_q <= 1'b0;  m_data_q  <= '0;
         m_eol_q   <= 1'b0;  m_eof_q   <= 1'b0;
      end else begin
         state_q   <= state_d;   en_q      <= en_d;      mode_q    <= mode_d;
         wv_q      <= wv_d;      done_q    <= done_d;    win_q     <= win_d;
         in_col_q  <= in_col_d;  in_row_q  <= in_row_d;
         out_col_q <= out_col_d; out_row_q <= out_row_d;
         win_col_q <= win_col_d; win_row_q <= win_row_d;
         m_valid_q <= m_valid_d; m_data_q  <= m_data_d;
         m_eol_q   <= m_eol_d;   m_eof_q   <= m_eof_d;
      end
   end
endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Scoreboard bench: each frame's expected outputs come from a 2-D clamp/zero
// reference model; a negedge monitor pops and compares on every output transfer.
module tb_gaussian_blur_stream;
   localparam int W  = 7;
   localparam int H  = 5;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          border_mode = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          m_ready = 1'b1;
   logic          s_ready, m_valid, m_eol, m_eof;
   logic [DW-1:0] m_data;

   gaussian_blur_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .border_mode(border_mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_eol(m_eol), .m_eof(m_eof));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          eol;
      logic          eof;
   } exp_t;

   exp_t sb[$];
   int   img[H][W];
   int   checks = 0, errors = 0;
   int   tmo_cnt = 0, tmo_seen = 0;
   int   since_rst = 0;
   bit   stall_en = 1'b0, last_px = 1'b0, end_req = 1'b0;
   bit   in_flush = 1'b0, hold_v = 1'b0;
   exp_t hold_x;

   function automatic int px_at(int r, int c, bit repl);
      if (r < 0 || r >= H || c < 0 || c >= W) begin
         if (!repl) return 0;
         r = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
         c = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
      end
      return img[r][c];
   endfunction

   task automatic push_expected(input bit repl);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            int   s;
            exp_t e;
            s = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * px_at(r + dr, c + dc, repl);
            e.d   = DW'((s + 8) / 16);
            e.eol = (c == W - 1);
            e.eof = (c == W - 1) && (r == H - 1);
            sb.push_back(e);
         end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (end_req) begin
         check("queue_empty_at_end", sb.size(), 0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
      if (tmo_cnt != tmo_seen) begin
         checks++;
         errors++;
         $display("FAIL s_ready_timeout actual=no_handshake expected=handshake within 500 cycles");
         tmo_seen = tmo_cnt;
      end
      if (!rst_n) begin
         check("rst_m_valid", m_valid, 0);
         check("rst_s_ready", s_ready, 0);
         check("rst_m_data", m_data, 0);
         check("rst_m_eol_eof", {m_eol, m_eof}, 0);
         sb.delete();
         hold_v    = 1'b0;
         in_flush  = 1'b0;
         since_rst = 0;
      end else begin
         since_rst++;
         if (since_rst == 1) check("s_ready_before_first_clk", s_ready, 0);
         if (since_rst == 2) check("s_ready_after_first_clk", s_ready, 1);
         if (hold_v) begin
            check("stall_m_valid", m_valid, 1);
            check("stall_hold", {m_data, m_eol, m_eof}, hold_x);
         end
         if (in_flush) check("flush_s_ready", s_ready, 0);
         if (s_valid && s_ready && last_px) in_flush = 1'b1;
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%0d expected=no output", m_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("m_data", m_data, e.d);
               check("m_eol", m_eol, e.eol);
               check("m_eof", m_eof, e.eof);
            end
            if (m_eof) in_flush = 1'b0;
         end
         hold_v = m_valid && !m_ready;
         hold_x = {m_data, m_eol, m_eof};
      end
   end

   always @(posedge clk) begin
      #1;
      m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_px(input logic [DW-1:0] d, input bit last);
      int n;
      n = 0;
      s_valid = 1'b1;
      s_data  = d;
      last_px = last;
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready && n < 500);
      if (!s_ready) tmo_cnt++;
      tick();
      s_valid = 1'b0;
      last_px = 1'b0;
   endtask

   // kind: 0 constant val, 1 impulse val at (2,2), 2 ramp, 3 random
   task automatic send_frame(input int kind, input int val, input bit repl,
                             input int gap_max, input int abort_at);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (kind)
               0:       img[r][c] = val;
               1:       img[r][c] = (r == 2 && c == 2) ? val : 0;
               2:       img[r][c] = ((r * W + c) * 7) % 256;
               default: img[r][c] = int'($urandom_range(0, 255));
            endcase
      push_expected(repl);
      border_mode = repl;
      for (int k = 0; k < W * H; k++) begin
         send_px(DW'(img[k / W][k % W]), k == W * H - 1);
         if (k == 0) border_mode = ~repl;
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
         if (k == abort_at) begin
            rst_n = 1'b0;
            repeat (3) tick();
            rst_n = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (4) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      send_frame(0, 100, 1'b1, 0, -1);
      send_frame(0, 100, 1'b0, 0, -1);
      send_frame(1, 160, 1'b0, 0, -1);
      send_frame(0, 255, 1'b1, 0, -1);
      send_frame(3, 0, 1'b0, 0, -1);
      stall_en = 1'b1;
      send_frame(2, 0, 1'b1, 3, -1);
      send_frame(3, 0, 1'b0, 2, -1);
      send_frame(3, 0, 1'b1, 2, -1);
      stall_en = 1'b0;
      for (int i = 0; i < 2000 && sb.size() != 0; i++) tick();
      send_frame(3, 0, 1'b1, 0, W + 4);
      repeat (3) tick();
      send_frame(0, 50, 1'b1, 0, -1);
      for (int i = 0; i < 2000 && sb.size() != 0; i++) tick();
      repeat (5) tick();
      end_req = 1'b1;
      repeat (20) tick();
      $display("FAIL summary_not_reached actual=running expected=finished");
      $fatal(1);
   end
endmodule

// File: doc/gaussian_blur_stream.md
Name: gaussian_blur_stream

Overview:
Streaming 3x3 Gaussian blur (kernel 1 2 1 / 2 4 2 / 1 2 1, divide by 16) over raster-order frames of IMG_W x IMG_H pixels. It is the parametrised successor of the single-window blur. It adds:
- real line buffering, so the window is spatially correct;
- valid/ready handshakes on both sides;
- selectable border handling;
- rounding;
- an end-of-frame flush.
It sits between the pixel source and downstream image stages in the processing chain.

Parameters:
DATA_W, 8, pixel width in bits.
IMG_W, 640, pixels per line (>=3).
IMG_H, 480, lines per frame (>=3).

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
border_mode  in  1  0 = zero padding, 1 = replicate edge pixel; sampled when pixel 0 of a frame is accepted.
s_valid  in  1  input pixel valid.
s_ready  out  1  block can accept an input pixel.
s_data  in  DATA_W  input pixel, raster order.
m_valid  out  1  output pixel valid.
m_ready  in  1  downstream accepts output.
m_data  out  DATA_W  blurred pixel.
m_eol  out  1  m_data is the last pixel of a line.
m_eof  out  1  m_data is the last pixel of a frame.

Behaviour:
- Reset (asynchronous, rst_n low):
  - m_valid=0, m_data=0, m_eol=0, m_eof=0, s_ready=0.
  - All counters cleared; FSM to IDLE.
  - s_ready goes to 1 on the first clk after rst_n deasserts.
  - Line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame; the next accepted pixel is pixel (0,0) of a new frame.
- Transfers: input on s_valid&s_ready, output on m_valid&m_ready.
  - m_data/m_eol/m_eof stay stable while m_valid=1 and m_ready=0.
  - Single output register. s_ready is deasserted when that register is full and m_ready=0, so the whole pipeline stalls with no data loss.
- FSM states:
  - IDLE: s_ready=1. First accept latches border_mode and goes to FILL.
  - FILL: accepting pixels; no output yet. Leaves after IMG_W+1 pixels have been accepted in the frame, going to RUN.
  - RUN: each accepted input index k (raster) produces output index k-(IMG_W+1). The output register loads one cycle after the accept. On accepting the last input pixel (IMG_H-1, IMG_W-1) it goes to FLUSH.
  - FLUSH: s_ready=0. It generates the remaining IMG_W+1 outputs without input, one per cycle when not stalled. After the m_eof transfer it returns to IDLE.
- Window and border handling:
  - Window center is output pixel (r,c). Taps come from two line buffers (lines r-1 and r) plus the current line.
  - Out-of-frame taps (r=0, r=IMG_H-1, c=0, c=IMG_W-1) are forced to 0 in zero mode.
  - In replicate mode they take the nearest in-frame pixel (clamp row/col index). Corners clamp on both axes.
- Arithmetic:
  - sum width DATA_W+4, unsigned.
  - m_data = (sum + 8) >> 4.
  - Maximum sum is 16*(2^DATA_W-1), so the result never exceeds full scale and no clamp is needed.
- m_eol is asserted for c=IMG_W-1. m_eof is asserted for (IMG_H-1, IMG_W-1), together with m_eol.
- Back-to-back frames: pixel 0 of the next frame is accepted only after FLUSH completes (IDLE). There is no overlap.

Decomposition:
- Package gaussian_pkg holds:
  - kernel weight constants;
  - NORM_SHIFT=4 and the rounding constant 8;
  - the border-mode encoding (BORDER_ZERO, BORDER_REPL);
  - the FSM state encoding (IDLE, FILL, RUN, FLUSH).
- Sub-module gaussian_line_buffer: a single-port-per-cycle IMG_W x DATA_W circular line store with a write-enable/advance input. It is instantiated twice, chained so line r feeds line r-1.
- Window registers, border muxing, MAC tree and FSM stay in the top.

Test Plan:
- 4x4 frame, all pixels 100, border_mode=1, m_ready=1 -> 16 outputs all 100; m_eol on outputs 3,7,11,15; m_eof only on output 15.
- Same frame, border_mode=0 -> corners 56, non-corner edges 75, interior 100.
- 5x5 frame, single 160 at (2,2), others 0, mode 0 -> (2,2)=40; (1,2),(3,2),(2,1),(2,3)=20; diagonals=10; all others 0.
- 4x4 all 255, mode 1 -> all outputs 255 (4088>>4), no wrap.
- 8x4 ramp, m_ready toggled pseudo-randomly and s_valid gapped -> output sequence identical to the uninterrupted run; m_data held stable during stalls; s_ready low throughout FLUSH.
- Reset asserted mid-RUN of frame 1, then a full constant-50 frame sent -> no outputs from frame 1 after reset; frame 2 outputs all 50 (mode 1) with exactly one m_eof.
